// File: rtl/dac_player_pkg.sv
// Shared definitions for the DAC waveform player.
//   state_e          : FSM states, encoding is visible on state_out.
//   SAMPLES_PER_BEAT : I/Q samples packed into one stream beat.
//   SAMPLE_BITS      : width of one packed {I, Q} sample.
//   I_/Q_ MSB/LSB    : slice of I and Q within a packed sample, same as the ADC path.
package dac_player_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_ARMED = 3'd2,
    ST_PLAY  = 3'd3
  } state_e;

  localparam int SAMPLES_PER_BEAT = 2;
  localparam int SAMPLE_BITS      = 32;

  localparam int I_MSB = 31;
  localparam int I_LSB = 16;
  localparam int Q_MSB = 15;
  localparam int Q_LSB = 0;

endpackage

// File: rtl/waveform_ram.sv
// Simple dual-port waveform store, written to block RAM.
//   clk_i   : clock
//   we_i    : write enable, waddr_i/wdata_i : write port
//   re_i    : read enable, raddr_i : read address
//   rdata_o : registered read data, one cycle after re_i; holds while re_i is low
module waveform_ram #(
  parameter int ADDR_WIDTH = 10,
  parameter int DATA_WIDTH = 64
) (
  input  logic                  clk_i,
  input  logic                  we_i,
  input  logic [ADDR_WIDTH-1:0] waddr_i,
  input  logic [DATA_WIDTH-1:0] wdata_i,
  input  logic                  re_i,
  input  logic [ADDR_WIDTH-1:0] raddr_i,
  output logic [DATA_WIDTH-1:0] rdata_o
);

  logic [DATA_WIDTH-1:0] mem_q [2**ADDR_WIDTH];

  always_ff @(posedge clk_i) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
    if (re_i) rdata_o <= mem_q[raddr_i];
  end

endmodule

// File: rtl/dac_waveform_player.sv
// DAC waveform player: loads a waveform from an AXI4-Stream slave into RAM,
// then replays it as one {I, Q} sample per clock when triggered.
//   aclk, cpu_reset          : clock, synchronous active-high reset
//   s_axis_*                 : waveform load stream (2 samples per beat, low half first)
//   load_start               : level, begin a new load
//   play_trigger             : rising edge starts playback from ARMED
//   play_abort               : level, stop playback without play_done
//   play_repeat              : extra passes over the waveform
//   dac_data_i/q/valid       : sample output, data forced to 0 when not valid
//   play_active, play_done   : status, play_done pulses at a normal end
//   load_done, load_overflow : load status, overflow is sticky until next load
//   wave_len_words           : stored beat count
//   state_out                : FSM state for debug
module dac_waveform_player
  import dac_player_pkg::*;
#(
  parameter int DAC_AXI_DATA_WIDTH = 64,
  parameter int ADDR_WIDTH         = 10,
  parameter int SAMPLE_WIDTH       = 16
) (
  input  logic                          aclk,
  input  logic                          cpu_reset,
  input  logic [DAC_AXI_DATA_WIDTH-1:0] s_axis_tdata,
  input  logic                          s_axis_tvalid,
  input  logic                          s_axis_tlast,
  input  logic [DAC_AXI_DATA_WIDTH/8-1:0] s_axis_tkeep,
  output logic                          s_axis_tready,
  input  logic                          load_start,
  input  logic                          play_trigger,
  input  logic                          play_abort,
  input  logic [15:0]                   play_repeat,
  output logic [SAMPLE_WIDTH-1:0]       dac_data_i,
  output logic [SAMPLE_WIDTH-1:0]       dac_data_q,
  output logic                          dac_data_valid,
  output logic                          play_active,
  output logic                          play_done,
  output logic                          load_done,
  output logic                          load_overflow,
  output logic [ADDR_WIDTH:0]           wave_len_words,
  output logic [2:0]                    state_out
);

  localparam logic [ADDR_WIDTH:0] DEPTH_C = {1'b1, {ADDR_WIDTH{1'b0}}};

  state_e                        state_q;
  logic [ADDR_WIDTH:0]           count_q;
  logic [ADDR_WIDTH-1:0]         rd_ptr_q;
  logic [15:0]                   pass_cnt_q;
  logic                          half_q;
  logic                          issuing_q;
  logic                          trig_prev_q;
  logic                          vld_p1;
  logic                          half_p1;
  logic [DAC_AXI_DATA_WIDTH-1:0] rdata;
  logic [SAMPLE_BITS-1:0]        sample;
  logic                          hs;
  logic                          ram_we;
  logic                          ram_re;
  logic                          trig_edge;
  logic                          last_beat;
  logic                          unused_tkeep;

  // tkeep is required to be all ones, so its value carries no information.
  assign unused_tkeep = &s_axis_tkeep;

  assign s_axis_tready = (state_q == ST_LOAD);
  assign hs            = s_axis_tvalid && s_axis_tready;
  assign ram_we        = hs && (count_q < DEPTH_C);
  // One read per beat: the RAM output holds for the high-half cycle.
  assign ram_re        = (state_q == ST_PLAY) && issuing_q && !half_q;
  assign trig_edge     = play_trigger && !trig_prev_q;
  assign last_beat     = ({1'b0, rd_ptr_q} == (wave_len_words - 1'b1));
  assign sample        = half_p1 ? rdata[SAMPLES_PER_BEAT*SAMPLE_BITS-1:SAMPLE_BITS]
                                 : rdata[SAMPLE_BITS-1:0];
  assign play_active   = (state_q == ST_PLAY);
  assign state_out     = state_q;

  waveform_ram #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .DATA_WIDTH (DAC_AXI_DATA_WIDTH)
  ) u_ram (
    .clk_i   (aclk),
    .we_i    (ram_we),
    .waddr_i (count_q[ADDR_WIDTH-1:0]),
    .wdata_i (s_axis_tdata),
    .re_i    (ram_re),
    .raddr_i (rd_ptr_q),
    .rdata_o (rdata)
  );

  always_ff @(posedge aclk) begin
    if (cpu_reset) begin
      state_q        <= ST_IDLE;
      count_q        <= '0;
      rd_ptr_q       <= '0;
      pass_cnt_q     <= '0;
      half_q         <= 1'b0;
      issuing_q      <= 1'b0;
      trig_prev_q    <= 1'b0;
      vld_p1         <= 1'b0;
      half_p1        <= 1'b0;
      dac_data_i     <= '0;
      dac_data_q     <= '0;
      dac_data_valid <= 1'b0;
      play_done      <= 1'b0;
      load_done      <= 1'b0;
      load_overflow  <= 1'b0;
      wave_len_words <= '0;
    end else begin
      trig_prev_q    <= play_trigger;
      load_done      <= 1'b0;
      play_done      <= 1'b0;
      vld_p1         <= 1'b0;
      dac_data_valid <= 1'b0;
      dac_data_i     <= '0;
      dac_data_q     <= '0;

      case (state_q)
        ST_IDLE: begin
          if (load_start) begin
            state_q       <= ST_LOAD;
            count_q       <= '0;
            load_overflow <= 1'b0;
          end
        end

        ST_LOAD: begin
          if (hs) begin
            if (count_q < DEPTH_C) count_q <= count_q + 1'b1;
            else                   load_overflow <= 1'b1;
            if (s_axis_tlast) begin
              wave_len_words <= (count_q < DEPTH_C) ? count_q + 1'b1 : count_q;
              load_done      <= 1'b1;
              state_q        <= ST_ARMED;
            end
          end
        end

        ST_ARMED: begin
          if (load_start) begin
            state_q       <= ST_LOAD;
            count_q       <= '0;
            load_overflow <= 1'b0;
          end else if (trig_edge) begin
            state_q    <= ST_PLAY;
            pass_cnt_q <= play_repeat;
            rd_ptr_q   <= '0;
            half_q     <= 1'b0;
            issuing_q  <= 1'b1;
          end
        end

        ST_PLAY: begin
          if (play_abort) begin
            state_q   <= ST_ARMED;
            issuing_q <= 1'b0;
          end else begin
            // Stage p1: RAM read in flight, half select travels alongside.
            vld_p1  <= issuing_q;
            half_p1 <= half_q;
            // Output stage: pick the half of the beat read last cycle.
            dac_data_valid <= vld_p1;
            if (vld_p1) begin
              dac_data_i <= sample[I_MSB:I_LSB];
              dac_data_q <= sample[Q_MSB:Q_LSB];
            end

            if (issuing_q) begin
              if (!half_q) begin
                half_q <= 1'b1;
              end else begin
                half_q <= 1'b0;
                if (last_beat) begin
                  rd_ptr_q <= '0;
                  if (pass_cnt_q != 16'd0) pass_cnt_q <= pass_cnt_q - 16'd1;
                  else                     issuing_q  <= 1'b0;
                end else begin
                  rd_ptr_q <= rd_ptr_q + 1'b1;
                end
              end
            end

            // Pipeline fully drained after the final sample was shown.
            if (!issuing_q && !vld_p1 && dac_data_valid) begin
              play_done <= 1'b1;
              state_q   <= ST_ARMED;
            end
          end
        end

        default: state_q <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dac_waveform_player.sv
module tb_dac_waveform_player;

  localparam int AW = 3;

  logic          clk = 1'b0;
  logic          cpu_reset;
  logic [63:0]   s_axis_tdata;
  logic          s_axis_tvalid;
  logic          s_axis_tlast;
  logic [7:0]    s_axis_tkeep;
  logic          s_axis_tready;
  logic          load_start;
  logic          play_trigger;
  logic          play_abort;
  logic [15:0]   play_repeat;
  logic [15:0]   dac_data_i;
  logic [15:0]   dac_data_q;
  logic          dac_data_valid;
  logic          play_active;
  logic          play_done;
  logic          load_done;
  logic          load_overflow;
  logic [AW:0]   wave_len_words;
  logic [2:0]    state_out;

  dac_waveform_player #(
    .DAC_AXI_DATA_WIDTH (64),
    .ADDR_WIDTH         (AW),
    .SAMPLE_WIDTH       (16)
  ) dut (
    .aclk           (clk),
    .cpu_reset      (cpu_reset),
    .s_axis_tdata   (s_axis_tdata),
    .s_axis_tvalid  (s_axis_tvalid),
    .s_axis_tlast   (s_axis_tlast),
    .s_axis_tkeep   (s_axis_tkeep),
    .s_axis_tready  (s_axis_tready),
    .load_start     (load_start),
    .play_trigger   (play_trigger),
    .play_abort     (play_abort),
    .play_repeat    (play_repeat),
    .dac_data_i     (dac_data_i),
    .dac_data_q     (dac_data_q),
    .dac_data_valid (dac_data_valid),
    .play_active    (play_active),
    .play_done      (play_done),
    .load_done      (load_done),
    .load_overflow  (load_overflow),
    .wave_len_words (wave_len_words),
    .state_out      (state_out)
  );

  always #2 clk = ~clk;

  typedef struct {
    int nbeats;
    int rep;
    bit gappy;
    int exp_len;
    bit exp_ovf;
  } vec_t;

  vec_t        vecs[4];
  logic [31:0] sb[$];
  int          tests = 0;
  int          fails = 0;
  int          done_seen = 0;
  int          exp_done = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Sample s (0-based) of vector v; v=0 gives 0x0001_0002, 0x0002_0004, ...
  function automatic logic [31:0] smp(input int v, input int s);
    logic [15:0] iv;
    logic [15:0] qv;
    iv = 16'(v * 256 + s + 1);
    qv = 16'(v * 4096 + 2 * (s + 1));
    return {iv, qv};
  endfunction

  // Scoreboard consumer: every valid output sample must match the queue head.
  always @(negedge clk) begin
    if (dac_data_valid === 1'b1) begin
      if (sb.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_sample: got %0h expected none", {dac_data_i, dac_data_q});
      end else begin
        chk("sample", {32'd0, dac_data_i, dac_data_q}, {32'd0, sb.pop_front()});
      end
    end
    if (play_done === 1'b1) done_seen++;
  end

  task automatic load_wave(input int v, input int nbeats, input bit gappy,
                           input int exp_len, input bit exp_ovf);
    load_start = 1'b1;
    @(posedge clk); #1;
    load_start = 1'b0;
    chk("load_state", 64'(state_out), 64'd1);
    chk("load_tready", 64'(s_axis_tready), 64'd1);
    chk("load_ovf_clear", 64'(load_overflow), 64'd0);
    for (int b = 0; b < nbeats; b++) begin
      s_axis_tdata  = {smp(v, 2 * b + 1), smp(v, 2 * b)};
      s_axis_tvalid = 1'b1;
      s_axis_tlast  = (b == nbeats - 1);
      @(posedge clk); #1;
      s_axis_tvalid = 1'b0;
      s_axis_tlast  = 1'b0;
      s_axis_tdata  = 64'hDEAD_BEEF_0BAD_F00D;
      if (gappy && b != nbeats - 1) begin
        repeat (2) begin @(posedge clk); #1; end
      end
    end
    chk("load_done", 64'(load_done), 64'd1);
    chk("wave_len", 64'(wave_len_words), 64'(exp_len));
    chk("load_overflow", 64'(load_overflow), 64'(exp_ovf));
    chk("armed_state", 64'(state_out), 64'd2);
    chk("armed_tready", 64'(s_axis_tready), 64'd0);
    @(posedge clk); #1;
    chk("load_done_pulse", 64'(load_done), 64'd0);
  endtask

  task automatic play(input int v, input int rep, input int len);
    int cnt;
    for (int p = 0; p <= rep; p++)
      for (int s = 0; s < 2 * len; s++) sb.push_back(smp(v, s));
    exp_done++;
    play_repeat  = 16'(rep);
    play_trigger = 1'b1;
    @(posedge clk); #1;
    chk("play_active", 64'(play_active), 64'd1);
    @(posedge clk); #1;
    chk("latency_n1", 64'(dac_data_valid), 64'd0);
    @(posedge clk); #1;
    chk("latency_n2", 64'(dac_data_valid), 64'd1);
    play_trigger = 1'b0;
    cnt = 1;
    for (int t = 0; t < 300; t++) begin
      @(posedge clk); #1;
      if (dac_data_valid !== 1'b1) break;
      cnt++;
    end
    chk("valid_cycles", 64'(cnt), 64'(2 * len * (rep + 1)));
    chk("play_done", 64'(play_done), 64'd1);
    chk("data_zero_idle", {32'd0, dac_data_i, dac_data_q}, 64'd0);
    chk("end_state", 64'(state_out), 64'd2);
    @(posedge clk); #1;
    chk("play_done_pulse", 64'(play_done), 64'd0);
  endtask

  initial begin
    vecs[0] = '{nbeats: 4,  rep: 0, gappy: 1'b0, exp_len: 4, exp_ovf: 1'b0};
    vecs[1] = '{nbeats: 2,  rep: 2, gappy: 1'b0, exp_len: 2, exp_ovf: 1'b0};
    vecs[2] = '{nbeats: 10, rep: 0, gappy: 1'b0, exp_len: 8, exp_ovf: 1'b1};
    vecs[3] = '{nbeats: 3,  rep: 0, gappy: 1'b1, exp_len: 3, exp_ovf: 1'b0};

    cpu_reset     = 1'b1;
    s_axis_tdata  = '0;
    s_axis_tvalid = 1'b0;
    s_axis_tlast  = 1'b0;
    s_axis_tkeep  = 8'hFF;
    load_start    = 1'b0;
    play_trigger  = 1'b0;
    play_abort    = 1'b0;
    play_repeat   = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_outputs", {s_axis_tready, dac_data_i, dac_data_q, dac_data_valid, play_active,
                          play_done, load_done, load_overflow, wave_len_words, state_out}, 64'd0);
    cpu_reset = 1'b0;
    @(posedge clk); #1;
    chk("idle_state", 64'(state_out), 64'd0);

    for (int i = 0; i < 4; i++) begin
      load_wave(i, vecs[i].nbeats, vecs[i].gappy, vecs[i].exp_len, vecs[i].exp_ovf);
      play(i, vecs[i].rep, vecs[i].exp_len);
    end

    // Abort after three samples of the 3-beat waveform, then retrigger.
    for (int s = 0; s < 6; s++) sb.push_back(smp(3, s));
    play_repeat  = 16'd0;
    play_trigger = 1'b1;
    @(posedge clk); #1;
    play_trigger = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    chk("abort_pre_valid", 64'(dac_data_valid), 64'd1);
    play_abort = 1'b1;
    @(posedge clk); #1;
    play_abort = 1'b0;
    chk("abort_valid", 64'(dac_data_valid), 64'd0);
    chk("abort_state", 64'(state_out), 64'd2);
    chk("abort_no_done", 64'(play_done), 64'd0);
    chk("abort_consumed", 64'(sb.size()), 64'd3);
    sb.delete();
    repeat (3) @(posedge clk);
    #1;
    play(3, 0, 3);

    // Reset in the middle of playback.
    for (int s = 0; s < 6; s++) sb.push_back(smp(3, s));
    play_trigger = 1'b1;
    @(posedge clk); #1;
    play_trigger = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    cpu_reset = 1'b1;
    @(posedge clk); #1;
    cpu_reset = 1'b0;
    chk("midplay_reset_outputs", {s_axis_tready, dac_data_i, dac_data_q, dac_data_valid, play_active,
                                  play_done, load_done, load_overflow, wave_len_words, state_out}, 64'd0);
    sb.delete();
    @(posedge clk); #1;
    play_trigger = 1'b1;
    @(posedge clk); #1;
    play_trigger = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    chk("post_reset_trigger_ignored", {dac_data_valid, play_active, state_out}, 64'd0);

    load_wave(0, 4, 1'b0, 4, 1'b0);
    play(0, 0, 4);

    repeat (3) @(posedge clk);
    #1;
    chk("done_pulse_count", 64'(done_seen), 64'(exp_done));
    chk("scoreboard_empty", 64'(sb.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/dac_waveform_player.md
Name: dac_waveform_player

Overview:
- AXI4-Stream slave that loads a DAC waveform into on-chip RAM, then replays it to the FMC150 DAC sample path on a trigger. Mirror of the ADC capture path.
- Sits in the 245.76 MHz DAC sample domain, downstream of the host/Ethernet stream. Any clock-domain crossing FIFO is external to this block.
- Emits one 32-bit I/Q sample per cycle, in the same packing as the ADC path: {I[31:16], Q[15:0]}.

Parameters:
- DAC_AXI_DATA_WIDTH, 64, stream beat width. Fixed at two I/Q samples per beat.
- ADDR_WIDTH, 10, RAM address width. Depth DEPTH = 2**ADDR_WIDTH beats.
- SAMPLE_WIDTH, 16, width of each I and Q sample.

Ports:
- aclk  in  1  sample clock (245.76 MHz).
- cpu_reset  in  1  synchronous, active-high reset.
- s_axis_tdata  in  64  waveform beat. Sample0 = [31:0], sample1 = [63:32].
- s_axis_tvalid  in  1  beat valid.
- s_axis_tlast  in  1  last beat of the waveform.
- s_axis_tkeep  in  8  ignored. Must be all ones.
- s_axis_tready  out  1  high only in LOAD.
- load_start  in  1  level; starts a new load.
- play_trigger  in  1  rising edge starts playback.
- play_abort  in  1  level; stops playback.
- play_repeat  in  16  extra passes; 0 = play once.
- dac_data_i  out  16  I sample.
- dac_data_q  out  16  Q sample.
- dac_data_valid  out  1  sample strobe.
- play_active  out  1  high in PLAY.
- play_done  out  1  one-cycle pulse at normal end of playback.
- load_done  out  1  one-cycle pulse on the tlast handshake.
- load_overflow  out  1  sticky; cleared on load_start.
- wave_len_words  out  ADDR_WIDTH+1  stored beat count.
- state_out  out  3  current FSM state, for debug.

Behaviour:
- Reset:
  - Clock and reset: one clock, aclk. cpu_reset is synchronous and active-high.
  - In reset, every output is 0, the state is IDLE, wave_len_words = 0, and the trigger edge register is cleared.
- States (state_out encoding): IDLE=0, LOAD=1, ARMED=2, PLAY=3.
- IDLE:
  - tready = 0.
  - load_start -> LOAD. On entry: wr_ptr=0, count=0, load_overflow=0.
- LOAD:
  - tready = 1.
  - Each handshake with count < DEPTH writes RAM[wr_ptr] and increments wr_ptr and count.
  - Each handshake with count == DEPTH is accepted and discarded, and sets load_overflow.
  - A handshake with tlast:
    - wave_len_words <= count after that beat has been counted;
    - load_done pulses;
    - state -> ARMED.
  - The first tlast beat therefore yields length >= 1.
  - load_start re-asserted in LOAD has no effect.
- ARMED:
  - tready = 0.
  - Rising edge of play_trigger (registered compare, prev=0 and cur=1) -> PLAY. play_repeat is latched into pass_cnt, rd_ptr=0, half=0.
  - load_start -> LOAD (reload). If load_start and a trigger edge arrive in the same cycle, load_start wins.
- PLAY:
  - Issue one RAM read per beat. The RAM has 1-cycle read latency.
  - Output low half (sample0), then high half (sample1), each for one cycle. Reads are prefetched so valid is continuous, with no bubbles between beats or between passes.
  - Latency: trigger edge sampled at edge N -> first dac_data_valid after edge N+2.
  - Pass end: after the last beat's sample1, if pass_cnt != 0, decrement it and restart at rd_ptr=0 seamlessly.
  - Total valid cycles = 2 * wave_len_words * (play_repeat + 1).
  - Normal end: the cycle after the final sample, dac_data_valid=0, play_done=1 for one cycle, state -> ARMED. The waveform is retained, so it can be retriggered.
  - play_abort in PLAY -> ARMED at the next edge; dac_data_valid=0 from that edge; no play_done.
  - Ignored in PLAY: trigger edges, load_start, and AXIS traffic (tready stays 0).
- dac_data_i/q = 0 whenever dac_data_valid = 0.
- play_active = (state == PLAY).
- A reset mid-operation returns to IDLE at the next edge, and a fresh load is required.
- Arithmetic: rd_ptr wraps at wave_len_words, not at DEPTH. pass_cnt is 16-bit and saturates at 0.

Decomposition:
- Shared package dac_player_pkg:
  - state enum (IDLE/LOAD/ARMED/PLAY);
  - SAMPLES_PER_BEAT=2;
  - I_MSB/I_LSB and Q_MSB/Q_LSB slice constants, matching the ADC packing.
- Sub-module waveform_ram:
  - simple dual-port, 1 write port and 1 read port;
  - DEPTH x 64;
  - registered read with 1-cycle latency;
  - must infer block RAM.

Test Plan:
- Load 4 beats, samples 0x0001_0002..0x0008_0010 with tlast on beat 4, then trigger with repeat=0 -> load_done pulse; wave_len_words=4; 8 valid samples in beat order, low half first; first valid at N+2; play_done on the cycle after the 8th sample.
- Load 2 beats, trigger with play_repeat=2 -> 12 contiguous valid cycles, sequence repeated 3x with no gap, a single play_done.
- With ADDR_WIDTH=3, send 10 beats (tlast on 10th) -> load_overflow=1; wave_len_words=8; playback of 16 samples = the first 8 beats.
- Drive tvalid toggling 1-0-0-1 during load -> only handshaked beats are stored, in order; playback data matches.
- Assert play_abort after 3 valid samples -> valid drops at the next edge; no play_done; state ARMED; a retrigger replays from sample 0.
- Assert cpu_reset mid-PLAY -> all outputs 0 at the next edge; state_out=0; a subsequent trigger is ignored until load_start and a new load.
